cam_frame_pingpong: RTL

Double-buffered frame store between the OV7670 capture path and the display/OLED readout. It generalises the single-bank frame buffer with parametrised image size and pixel width, ping-pong banks that swap only on frame boundaries (no tearing), and capture modes: continuous, snapshot, decimate and freeze. It also keeps committed-frame and dropped-frame counters for LED debug. Single clock domain; capture signals arrive already synchronised to wclk.

---
 rtl/cam_frame_pingpong.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cam_frame_pingpong.sv
// cam_frame_pingpong
// Double-buffered (ping-pong) frame store between the camera capture path
// and the display readout. The capture side writes one bank while the
// display reads the other. The banks swap only on frame boundaries, so the
// display never shows a torn frame.
//
// Capture modes are sampled at cap_sof:
//   00 continuous - every frame is kept
//   01 snapshot   - one frame is kept per snap_req
//   10 decimate   - 1 of every decim+1 frames is kept
//   11 freeze     - every frame is skipped
//
// Ports
//   wclk, rst             clock, synchronous active-high reset
//   mode, decim, snap_req capture-mode control
//   cap_sof/eof/we/addr/data    capture pixel stream (already on wclk)
//   disp_sof/eof/en/addr        display frame markers and read request
//   disp_data, disp_valid       read pixel, 1-cycle latency
//   wr_bank, rd_bank            current write / display bank
//   frame_cnt, frame_gray       committed frames (binary / Gray code)
//   drop_cnt                    frames lost to bank contention (saturating)
//   snap_done                   pulses when the snapshot frame is committed
module cam_frame_pingpong #(
    parameter int IMG_COLS = 80,
    parameter int IMG_ROWS = 60,
    parameter int ADDR_W   = 13,
    parameter int PIX_W    = 16,
    parameter int DECIM_W  = 4
) (
    input  logic               wclk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic [DECIM_W-1:0] decim,
    input  logic               snap_req,
    input  logic               cap_sof,
    input  logic               cap_eof,
    input  logic               cap_we,
    input  logic [ADDR_W-1:0]  cap_addr,
    input  logic [PIX_W-1:0]   cap_data,
    input  logic               disp_sof,
    input  logic               disp_eof,
    input  logic               disp_en,
    input  logic [ADDR_W-1:0]  disp_addr,
    output logic [PIX_W-1:0]   disp_data,
    output logic               disp_valid,
    output logic               wr_bank,
    output logic               rd_bank,
    output logic [7:0]         frame_cnt,
    output logic [7:0]         frame_gray,
    output logic [7:0]         drop_cnt,
    output logic               snap_done
);

    localparam int NPIX  = IMG_COLS * IMG_ROWS;
    localparam int IDX_W = ADDR_W + 1;
    localparam logic [IDX_W-1:0] NPIX_I = IDX_W'(NPIX);

    typedef enum logic [1:0] {W_IDLE, W_CAP, W_HOLD, W_SKIP} wstate_t;

    wstate_t            state_q, state_d;
    logic               wr_bank_q, wr_bank_d;
    logic               rd_bank_q, rd_bank_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;
    logic               snap_done_q, snap_done_d;
    logic               disp_busy_q, disp_busy_d;
    logic               pending_q, pending_d;
    logic               armed_q, armed_d;
    logic               snap_frame_q, snap_frame_d;  // frame being captured is the snapshot
    logic [DECIM_W-1:0] dec_cnt_q, dec_cnt_d;

    logic [PIX_W-1:0]   disp_data_q;
    logic               disp_valid_q;

    // Two banks packed back to back: bank 1 starts at NPIX.
    logic [PIX_W-1:0]   mem [0:2*NPIX-1];

    logic               wr_in_range, rd_in_range, wr_en;
    logic [IDX_W-1:0]   wr_idx, rd_idx;

    assign wr_in_range = ({1'b0, cap_addr} < NPIX_I);
    assign rd_in_range = ({1'b0, disp_addr} < NPIX_I);
    assign wr_idx = wr_bank_q ? ({1'b0, cap_addr} + NPIX_I) : {1'b0, cap_addr};
    assign rd_idx = rd_bank_q ? ({1'b0, disp_addr} + NPIX_I) : {1'b0, disp_addr};
    assign wr_en  = (state_q == W_CAP) && cap_we && wr_in_range;

    always_comb begin
        wstate_t st;
        logic    do_swap;
        logic    eval_sof;
        logic    keep;

        state_d      = state_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        frame_cnt_d  = frame_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        snap_done_d  = 1'b0;
        pending_d    = pending_q;
        armed_d      = armed_q;
        snap_frame_d = snap_frame_q;
        dec_cnt_d    = dec_cnt_q;
        st           = state_q;
        do_swap      = 1'b0;
        eval_sof     = 1'b0;
        keep         = 1'b0;

        // A simultaneous sof/eof leaves the display busy.
        disp_busy_d = disp_busy_q;
        if (disp_eof) begin
            disp_busy_d = 1'b0;
        end
        if (disp_sof) begin
            disp_busy_d = 1'b1;
        end

        // End-of-frame handling first; a same-cycle cap_sof is then
        // evaluated from W_IDLE if the writer landed there.
        case (state_q)
            W_IDLE: begin
                eval_sof = cap_sof;
            end
            W_CAP: begin
                if (cap_eof) begin
                    // A display ending in the same cycle frees the bank at once.
                    if (!disp_busy_q || disp_eof) begin
                        do_swap  = 1'b1;
                        st       = W_IDLE;
                        eval_sof = cap_sof;
                    end else begin
                        pending_d = 1'b1;
                        st        = W_HOLD;
                    end
                end
            end
            W_HOLD: begin
                if (cap_sof && drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
                if (pending_q && disp_eof) begin
                    do_swap   = 1'b1;
                    pending_d = 1'b0;
                    st        = W_IDLE;
                end
            end
            W_SKIP: begin
                if (cap_eof) begin
                    st       = W_IDLE;
                    eval_sof = cap_sof;
                end
            end
            default: st = W_IDLE;
        endcase

        if (eval_sof) begin
            case (mode)
                2'b00: keep = 1'b1;
                2'b01: keep = armed_q;
                2'b10: begin
                    keep      = (dec_cnt_q == '0);
                    dec_cnt_d = (dec_cnt_q >= decim) ? '0 : dec_cnt_q + 1'b1;
                end
                default: keep = 1'b0;
            endcase
            if (keep) begin
                st           = W_CAP;
                snap_frame_d = (mode == 2'b01);
                if (mode == 2'b01) begin
                    armed_d = 1'b0;
                end
            end else begin
                st = W_SKIP;
            end
        end

        if (snap_req) begin
            armed_d = 1'b1;
        end

        if (do_swap) begin
            wr_bank_d   = ~wr_bank_q;
            rd_bank_d   = wr_bank_q;
            frame_cnt_d = frame_cnt_q + 8'd1;
            snap_done_d = snap_frame_q;
        end

        state_d = st;
    end

    always_ff @(posedge wclk) begin
        if (rst) begin
            state_q      <= W_IDLE;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b1;
            frame_cnt_q  <= 8'd0;
            drop_cnt_q   <= 8'd0;
            snap_done_q  <= 1'b0;
            disp_busy_q  <= 1'b0;
            pending_q    <= 1'b0;
            armed_q      <= 1'b0;
            snap_frame_q <= 1'b0;
            dec_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            frame_cnt_q  <= frame_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            snap_done_q  <= snap_done_d;
            disp_busy_q  <= disp_busy_d;
            pending_q    <= pending_d;
            armed_q      <= armed_d;
            snap_frame_q <= snap_frame_d;
            dec_cnt_q    <= dec_cnt_d;
        end
    end

    // Frame memory write port; contents survive reset.
    always_ff @(posedge wclk) begin
        if (wr_en) begin
            mem[wr_idx] <= cap_data;
        end
    end

    // Registered read port; out-of-range addresses read as zero.
    always_ff @(posedge wclk) begin
        if (rst) begin
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
        end else begin
            disp_valid_q <= disp_en;
            if (disp_en) begin
                disp_data_q <= rd_in_range ? mem[rd_idx] : '0;
            end
        end
    end

    assign disp_data  = disp_data_q;
    assign disp_valid = disp_valid_q;
    assign wr_bank    = wr_bank_q;
    assign rd_bank    = rd_bank_q;
    assign frame_cnt  = frame_cnt_q;
    assign frame_gray = frame_cnt_q ^ (frame_cnt_q >> 1);
    assign drop_cnt   = drop_cnt_q;
    assign snap_done  = snap_done_q;

endmodule
